dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory between the scalar core load/store path and the vector core load/store path.
- Accepts level-held requests from both sides and issues at most one memory access per cycle.
- Routes read data back to the owner using a tagged latency pipeline, and drives per-requester stall signals.
- Sits between the scalar core, the vector core and the data memory in the RV32I-V top level.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- RD_LAT, 1, memory read latency in cycles from mem_re_o high to mem_rdata_i valid (1..4).
- MAX_WAIT, 8, consecutive denied cycles after which a waiting scalar request is forced through (1..255).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-low reset
- scalar_load_req_i  in  1  scalar load request, held until ack
- scalar_store_req_i  in  1  scalar store request, held until ack
- scalar_address_i  in  ADDR_W  scalar access address
- scalar_wdata_i  in  DATA_W  scalar store data
- scalar_ack_o  out  1  scalar request accepted this cycle
- scalar_stall_o  out  1  scalar request pending and not accepted
- scalar_rdata_o  out  DATA_W  scalar load data
- scalar_rvalid_o  out  1  scalar_rdata_o valid
- vec_re_i  in  1  vector load request
- vec_we_i  in  1  vector store request
- vec_load_address_i  in  ADDR_W  vector load address
- vec_store_address_i  in  ADDR_W  vector store address
- vec_wdata_i  in  DATA_W  vector store data
- vec_ack_o  out  1  vector access accepted this cycle
- vec_ack_is_store_o  out  1  qualifies vec_ack_o: 1=store, 0=load
- vector_stall_o  out  1  vector request pending and not accepted
- vec_rdata_o  out  DATA_W  vector load data
- vec_rvalid_o  out  1  vec_rdata_o valid
- mem_we_o  out  1  memory write enable
- mem_re_o  out  1  memory read enable
- mem_address_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (reset=0 at a clk edge):
  - All outputs go to 0.
  - The wait counter clears and the tag pipeline clears.
  - In-flight reads are discarded; no rvalid is produced for them after reset.
- Grant logic (combinational, cycle N):
  - Vector has priority. If any vector request is pending and wait_cnt<MAX_WAIT, vector wins; otherwise scalar wins if pending.
  - When wait_cnt==MAX_WAIT and a scalar request is pending, scalar wins.
  - Acks equal grants, in the same cycle N.
- Intra-requester order:
  - Vector: if vec_we_i and vec_re_i are both high, the store issues first and the load on a later grant.
  - Scalar: if load and store requests are both high, the store issues first.
- Stall: scalar_stall_o=(scalar_load_req_i|scalar_store_req_i)&~scalar_ack_o; vector_stall_o likewise.
- Issue: mem_* outputs are registered. The access granted in cycle N appears on mem_* in N+1. mem_re_o and mem_we_o are never both 1. With no grant, both are 0 and address/wdata hold their last value.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle where scalar is pending and not granted.
  - Clears on scalar grant or when no scalar request is pending.
- Read return:
  - A tag (valid, owner) is pushed into an RD_LAT-deep shift register in the issue cycle N+1.
  - At N+1+RD_LAT, mem_rdata_i passes combinationally to the owner's rdata_o, with rvalid_o=1 for exactly one cycle.
  - The non-owner's rvalid_o is 0 and its rdata_o holds its last value.
  - Back-to-back reads from alternating owners return in issue order, one per cycle.
- Requests are sampled every cycle; a requester may hold its request high to issue back-to-back accesses.
- Deasserting a request before its ack withdraws it without side effects.

Optional Feature:
- Macro: DMEM_ARB_PERF_CNT_EN.
- When defined, adds three outputs:
  - scalar_grant_cnt_o [31:0]: wrapping count of scalar grants.
  - vec_grant_cnt_o [31:0]: wrapping count of vector grants.
  - starve_cnt_o [15:0]: saturating count of forced scalar grants (wait_cnt==MAX_WAIT).
- All three clear on reset.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Scalar-only load, addr=0x100, RD_LAT=1, mem returns 0xDEADBEEF:
  - scalar_ack_o=1 in cycle N; mem_re_o=1 with mem_address_o=0x100 in N+1.
  - scalar_rvalid_o=1 with rdata=0xDEADBEEF in N+2; vector_stall_o=0 throughout.
- Scalar store (0x200, 0x55) and vector load (0x300) both requested in N:
  - Vector acked in N, scalar_stall_o=1.
  - Scalar acked in N+1 (vector dropped); mem_we_o=1 at 0x200 in N+2.
- Vector holds vec_re_i=1 continuously, scalar load pending, MAX_WAIT=8:
  - Scalar denied 8 cycles, then acked on the 9th.
  - One vector grant is skipped in that cycle; wait_cnt returns to 0.
- vec_we_i=1 and vec_re_i=1 together (store addr 0x40, load addr 0x80):
  - Store issues first (vec_ack_is_store_o=1), then load (vec_ack_is_store_o=0).
  - vec_rvalid_o=1 only for the load.
- RD_LAT=3, alternating scalar/vector loads back-to-back:
  - rvalid pulses alternate owners on consecutive cycles, each 3 cycles after its issue, with correct data routing.
- reset=0 asserted one cycle after a vector load issues:
  - All outputs 0 the next cycle; no vec_rvalid_o for the dropped load.
  - A new scalar request after reset is serviced normally.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the scalar and vector load/store paths.
// Define DMEM_ARB_PERF_CNT_EN to add grant and starvation performance counters.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scalar_load_req_i,
  input  logic              scalar_store_req_i,
  input  logic [ADDR_W-1:0] scalar_address_i,
  input  logic [DATA_W-1:0] scalar_wdata_i,
  output logic              scalar_ack_o,
  output logic              scalar_stall_o,
  output logic [DATA_W-1:0] scalar_rdata_o,
  output logic              scalar_rvalid_o,
  input  logic              vec_re_i,
  input  logic              vec_we_i,
  input  logic [ADDR_W-1:0] vec_load_address_i,
  input  logic [ADDR_W-1:0] vec_store_address_i,
  input  logic [DATA_W-1:0] vec_wdata_i,
  output logic              vec_ack_o,
  output logic              vec_ack_is_store_o,
  output logic              vector_stall_o,
  output logic [DATA_W-1:0] vec_rdata_o,
  output logic              vec_rvalid_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic [ADDR_W-1:0] mem_address_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
`ifdef DMEM_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       scalar_grant_cnt_o,
  output logic [31:0]       vec_grant_cnt_o,
  output logic [15:0]       starve_cnt_o
`endif
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef struct packed {
    logic valid;
    logic vec;
  } tag_t;

  logic              scalar_pending;
  logic              vec_pending;
  logic              force_scalar;
  logic              scalar_grant;
  logic              vec_grant;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;
  logic              issue_vec_q;
  tag_t              tag_in;
  tag_t [RD_LAT-1:0] tag_q;
  tag_t [RD_LAT-1:0] tag_d;
  logic              ret_valid;
  logic [DATA_W-1:0] scalar_rdata_q;
  logic [DATA_W-1:0] vec_rdata_q;

  // Grant: vector first unless the scalar side has waited MAX_WAIT cycles.
  assign scalar_pending = scalar_load_req_i | scalar_store_req_i;
  assign vec_pending    = vec_re_i | vec_we_i;
  assign force_scalar   = scalar_pending & (wait_cnt_q == WAIT_MAX);
  assign vec_grant      = reset & vec_pending & ~force_scalar;
  assign scalar_grant   = reset & scalar_pending & ~vec_grant;

  assign scalar_ack_o       = scalar_grant;
  assign vec_ack_o          = vec_grant;
  assign vec_ack_is_store_o = vec_grant & vec_we_i;
  assign scalar_stall_o     = reset & scalar_pending & ~scalar_grant;
  assign vector_stall_o     = reset & vec_pending & ~vec_grant;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!scalar_pending || scalar_grant) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q != WAIT_MAX) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Registered memory issue; stores take precedence within each requester.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_q    <= '0;
      mem_we_o      <= 1'b0;
      mem_re_o      <= 1'b0;
      mem_address_o <= '0;
      mem_wdata_o   <= '0;
      issue_vec_q   <= 1'b0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      mem_we_o   <= 1'b0;
      mem_re_o   <= 1'b0;
      if (vec_grant) begin
        issue_vec_q <= 1'b1;
        mem_we_o    <= vec_we_i;
        mem_re_o    <= ~vec_we_i;
        if (vec_we_i) begin
          mem_address_o <= vec_store_address_i;
          mem_wdata_o   <= vec_wdata_i;
        end else begin
          mem_address_o <= vec_load_address_i;
        end
      end else if (scalar_grant) begin
        issue_vec_q   <= 1'b0;
        mem_we_o      <= scalar_store_req_i;
        mem_re_o      <= ~scalar_store_req_i;
        mem_address_o <= scalar_address_i;
        if (scalar_store_req_i) begin
          mem_wdata_o <= scalar_wdata_i;
        end
      end
    end
  end

  // Tag pipeline tracks read ownership across the memory latency.
  assign tag_in = '{valid: mem_re_o, vec: issue_vec_q};

  if (RD_LAT == 1) begin : g_lat1
    assign tag_d = tag_in;
  end else begin : g_latn
    assign tag_d = {tag_q[RD_LAT-2:0], tag_in};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign ret_valid       = reset & tag_q[RD_LAT-1].valid;
  assign scalar_rvalid_o = ret_valid & ~tag_q[RD_LAT-1].vec;
  assign vec_rvalid_o    = ret_valid & tag_q[RD_LAT-1].vec;
  assign scalar_rdata_o  = scalar_rvalid_o ? mem_rdata_i : scalar_rdata_q;
  assign vec_rdata_o     = vec_rvalid_o ? mem_rdata_i : vec_rdata_q;

  // Non-owner read data holds the last value delivered to it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scalar_rdata_q <= '0;
      vec_rdata_q    <= '0;
    end else begin
      if (scalar_rvalid_o) scalar_rdata_q <= mem_rdata_i;
      if (vec_rvalid_o)    vec_rdata_q    <= mem_rdata_i;
    end
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  // Grant counters wrap; the forced-grant counter saturates.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scalar_grant_cnt_o <= '0;
      vec_grant_cnt_o    <= '0;
      starve_cnt_o       <= '0;
    end else begin
      if (scalar_grant) scalar_grant_cnt_o <= scalar_grant_cnt_o + 32'(1);
      if (vec_grant)    vec_grant_cnt_o    <= vec_grant_cnt_o + 32'(1);
      if (scalar_grant && force_scalar && (starve_cnt_o != 16'hFFFF)) begin
        starve_cnt_o <= starve_cnt_o + 16'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: cycle table at RD_LAT=1, plus starvation,
// withdrawal and RD_LAT=3 interleaved-return sequences.
module tb_dmem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        scalar_load_req_i, scalar_store_req_i;
  logic [31:0] scalar_address_i, scalar_wdata_i;
  logic        vec_re_i, vec_we_i;
  logic [31:0] vec_load_address_i, vec_store_address_i, vec_wdata_i;
  logic [31:0] mem_rdata_i;

  logic        scalar_ack_o, scalar_stall_o, scalar_rvalid_o;
  logic [31:0] scalar_rdata_o;
  logic        vec_ack_o, vec_ack_is_store_o, vector_stall_o, vec_rvalid_o;
  logic [31:0] vec_rdata_o;
  logic        mem_we_o, mem_re_o;
  logic [31:0] mem_address_o, mem_wdata_o;

  logic        d3_sack, d3_sstall, d3_srv, d3_vack, d3_vst, d3_vstall, d3_vrv;
  logic [31:0] d3_srd, d3_vrd;
  logic        d3_mwe, d3_mre;
  logic [31:0] d3_maddr, d3_mwd;

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] sgc, vgc, sgc3, vgc3;
  logic [15:0] stc, stc3;
`endif

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(8)) u_dut (
    .clk(clk), .reset(reset),
    .scalar_load_req_i(scalar_load_req_i), .scalar_store_req_i(scalar_store_req_i),
    .scalar_address_i(scalar_address_i), .scalar_wdata_i(scalar_wdata_i),
    .scalar_ack_o(scalar_ack_o), .scalar_stall_o(scalar_stall_o),
    .scalar_rdata_o(scalar_rdata_o), .scalar_rvalid_o(scalar_rvalid_o),
    .vec_re_i(vec_re_i), .vec_we_i(vec_we_i),
    .vec_load_address_i(vec_load_address_i), .vec_store_address_i(vec_store_address_i),
    .vec_wdata_i(vec_wdata_i), .vec_ack_o(vec_ack_o), .vec_ack_is_store_o(vec_ack_is_store_o),
    .vector_stall_o(vector_stall_o), .vec_rdata_o(vec_rdata_o), .vec_rvalid_o(vec_rvalid_o),
    .mem_we_o(mem_we_o), .mem_re_o(mem_re_o), .mem_address_o(mem_address_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_PERF_CNT_EN
    , .scalar_grant_cnt_o(sgc), .vec_grant_cnt_o(vgc), .starve_cnt_o(stc)
`endif
  );

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(8)) u_dut3 (
    .clk(clk), .reset(reset),
    .scalar_load_req_i(scalar_load_req_i), .scalar_store_req_i(scalar_store_req_i),
    .scalar_address_i(scalar_address_i), .scalar_wdata_i(scalar_wdata_i),
    .scalar_ack_o(d3_sack), .scalar_stall_o(d3_sstall),
    .scalar_rdata_o(d3_srd), .scalar_rvalid_o(d3_srv),
    .vec_re_i(vec_re_i), .vec_we_i(vec_we_i),
    .vec_load_address_i(vec_load_address_i), .vec_store_address_i(vec_store_address_i),
    .vec_wdata_i(vec_wdata_i), .vec_ack_o(d3_vack), .vec_ack_is_store_o(d3_vst),
    .vector_stall_o(d3_vstall), .vec_rdata_o(d3_vrd), .vec_rvalid_o(d3_vrv),
    .mem_we_o(d3_mwe), .mem_re_o(d3_mre), .mem_address_o(d3_maddr),
    .mem_wdata_o(d3_mwd), .mem_rdata_i(mem_rdata_i)
`ifdef DMEM_ARB_PERF_CNT_EN
    , .scalar_grant_cnt_o(sgc3), .vec_grant_cnt_o(vgc3), .starve_cnt_o(stc3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic        sl, ss;
    logic [31:0] sa, swd;
    logic        vre, vwe;
    logic [31:0] vla, vsa, vwd, mrd;
  } stim_t;

  // flags = {scalar_ack, scalar_stall, vec_ack, vec_is_store, vector_stall, mem_we, mem_re}
  typedef struct packed {
    logic [6:0]  flags;
    logic [31:0] maddr, mwd;
    logic        srv;
    logic [31:0] srd;
    logic        vrv;
    logic [31:0] vrd;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } row_t;

  localparam int NROWS = 23;
  row_t rows [NROWS];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic row_t mk(
    input logic rst, input logic sl, input logic ss, input logic [31:0] sa, input logic [31:0] swd,
    input logic vre, input logic vwe, input logic [31:0] vla, input logic [31:0] vsa,
    input logic [31:0] vwd, input logic [31:0] mrd, input logic [6:0] flags,
    input logic [31:0] maddr, input logic [31:0] mwd, input logic srv, input logic [31:0] srd,
    input logic vrv, input logic [31:0] vrd);
    row_t r;
    r.s = '{rst: rst, sl: sl, ss: ss, sa: sa, swd: swd, vre: vre, vwe: vwe,
            vla: vla, vsa: vsa, vwd: vwd, mrd: mrd};
    r.e = '{flags: flags, maddr: maddr, mwd: mwd, srv: srv, srd: srd, vrv: vrv, vrd: vrd};
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [136:0] act,
                       input logic [136:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h required %h", name, idx, act, exp);
    end
  endtask

  task automatic clear_inputs();
    scalar_load_req_i = 1'b0; scalar_store_req_i = 1'b0;
    scalar_address_i  = '0;   scalar_wdata_i     = '0;
    vec_re_i = 1'b0; vec_we_i = 1'b0;
    vec_load_address_i = '0; vec_store_address_i = '0; vec_wdata_i = '0;
    mem_rdata_i = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  // Vector holds a load while scalar waits; expect ndeny denials then a forced grant.
  task automatic starve_run(input int ndeny, input string name);
    for (int k = 0; k <= ndeny; k++) begin
      logic g;
      g = (k == ndeny);
      #2;
      check(name, k, 137'({scalar_ack_o, vec_ack_o, scalar_stall_o, vector_stall_o}),
            137'({g, ~g, ~g, g}));
      tick();
    end
  endtask

  initial begin
    exp_t obs;

    rows[0]  = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000000, 32'h0,32'h0, 0,32'h0, 0,32'h0);
    rows[1]  = mk(1, 1,0,32'h100,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b1000000, 32'h0,32'h0, 0,32'h0, 0,32'h0);
    rows[2]  = mk(1, 0,0,32'h100,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000001, 32'h100,32'h0, 0,32'h0, 0,32'h0);
    rows[3]  = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'hDEADBEEF,
                  7'b0000000, 32'h100,32'h0, 1,32'hDEADBEEF, 0,32'h0);
    rows[4]  = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h12345678,
                  7'b0000000, 32'h100,32'h0, 0,32'hDEADBEEF, 0,32'h0);
    rows[5]  = mk(1, 0,1,32'h200,32'h55, 1,0,32'h300,32'h0,32'h0, 32'h0,
                  7'b0110000, 32'h100,32'h0, 0,32'hDEADBEEF, 0,32'h0);
    rows[6]  = mk(1, 0,1,32'h200,32'h55, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b1000001, 32'h300,32'h0, 0,32'hDEADBEEF, 0,32'h0);
    rows[7]  = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'hCAFEF00D,
                  7'b0000010, 32'h200,32'h55, 0,32'hDEADBEEF, 1,32'hCAFEF00D);
    rows[8]  = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000000, 32'h200,32'h55, 0,32'hDEADBEEF, 0,32'hCAFEF00D);
    rows[9]  = mk(1, 0,0,32'h0,32'h0, 1,1,32'h80,32'h40,32'hA5A5A5A5, 32'h0,
                  7'b0011000, 32'h200,32'h55, 0,32'hDEADBEEF, 0,32'hCAFEF00D);
    rows[10] = mk(1, 0,0,32'h0,32'h0, 1,0,32'h80,32'h40,32'hA5A5A5A5, 32'h0,
                  7'b0010010, 32'h40,32'hA5A5A5A5, 0,32'hDEADBEEF, 0,32'hCAFEF00D);
    rows[11] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000001, 32'h80,32'hA5A5A5A5, 0,32'hDEADBEEF, 0,32'hCAFEF00D);
    rows[12] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h11112222,
                  7'b0000000, 32'h80,32'hA5A5A5A5, 0,32'hDEADBEEF, 1,32'h11112222);
    rows[13] = mk(1, 1,1,32'h500,32'h77, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b1000000, 32'h80,32'hA5A5A5A5, 0,32'hDEADBEEF, 0,32'h11112222);
    rows[14] = mk(1, 1,0,32'h500,32'h77, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b1000010, 32'h500,32'h77, 0,32'hDEADBEEF, 0,32'h11112222);
    rows[15] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000001, 32'h500,32'h77, 0,32'hDEADBEEF, 0,32'h11112222);
    rows[16] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h9,
                  7'b0000000, 32'h500,32'h77, 1,32'h9, 0,32'h11112222);
    rows[17] = mk(1, 0,0,32'h0,32'h0, 1,0,32'h600,32'h0,32'h0, 32'h0,
                  7'b0010000, 32'h500,32'h77, 0,32'h9, 0,32'h11112222);
    rows[18] = mk(0, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000001, 32'h600,32'h77, 0,32'h9, 0,32'h11112222);
    rows[19] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'hBAD0BAD0,
                  7'b0000000, 32'h0,32'h0, 0,32'h0, 0,32'h0);
    rows[20] = mk(1, 1,0,32'h700,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b1000000, 32'h0,32'h0, 0,32'h0, 0,32'h0);
    rows[21] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0,
                  7'b0000001, 32'h700,32'h0, 0,32'h0, 0,32'h0);
    rows[22] = mk(1, 0,0,32'h0,32'h0, 0,0,32'h0,32'h0,32'h0, 32'h0F0F0F0F,
                  7'b0000000, 32'h700,32'h0, 1,32'h0F0F0F0F, 0,32'h0);

    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;

    for (int i = 0; i < NROWS; i++) begin
      reset               = rows[i].s.rst;
      scalar_load_req_i   = rows[i].s.sl;
      scalar_store_req_i  = rows[i].s.ss;
      scalar_address_i    = rows[i].s.sa;
      scalar_wdata_i      = rows[i].s.swd;
      vec_re_i            = rows[i].s.vre;
      vec_we_i            = rows[i].s.vwe;
      vec_load_address_i  = rows[i].s.vla;
      vec_store_address_i = rows[i].s.vsa;
      vec_wdata_i         = rows[i].s.vwd;
      mem_rdata_i         = rows[i].s.mrd;
      #2;
      obs = {scalar_ack_o, scalar_stall_o, vec_ack_o, vec_ack_is_store_o, vector_stall_o,
             mem_we_o, mem_re_o, mem_address_o, mem_wdata_o,
             scalar_rvalid_o, scalar_rdata_o, vec_rvalid_o, vec_rdata_o};
      check("row", i, 137'(obs), 137'(rows[i].e));
      tick();
    end

    // Starvation: forced grant after 8 denials, then counter restarts from zero.
    do_reset();
    vec_re_i = 1'b1; vec_load_address_i = 32'h900;
    scalar_load_req_i = 1'b1; scalar_address_i = 32'hA00;
    starve_run(8, "starve_first");
    #2;
    check("forced_issue", 0, 137'({mem_re_o, mem_we_o, mem_address_o}),
          137'({1'b1, 1'b0, 32'hA00}));
    starve_run(8, "starve_again");

    // Withdrawal clears the wait count without side effects.
    tick(); tick(); tick();
    scalar_load_req_i = 1'b0;
    #2;
    check("withdraw_noack", 0, 137'({scalar_ack_o, scalar_stall_o, vec_ack_o}),
          137'({1'b0, 1'b0, 1'b1}));
    tick();
    scalar_load_req_i = 1'b1;
    starve_run(8, "starve_after_withdraw");

    // RD_LAT=3: alternating scalar/vector loads return in issue order.
    do_reset();
    for (int c = 0; c < 10; c++) begin
      logic        es, ev;
      logic [31:0] d;
      clear_inputs();
      case (c)
        0: begin scalar_load_req_i = 1'b1; scalar_address_i = 32'h10; end
        1: begin vec_re_i = 1'b1; vec_load_address_i = 32'h20; end
        2: begin scalar_load_req_i = 1'b1; scalar_address_i = 32'h30; end
        3: begin vec_re_i = 1'b1; vec_load_address_i = 32'h40; end
        default: ;
      endcase
      d = 32'hD000_0000 + 32'(c);
      mem_rdata_i = d;
      es = (c == 4) || (c == 6);
      ev = (c == 5) || (c == 7);
      #2;
      check("lat3_rvalid", c, 137'({d3_srv, d3_vrv}), 137'({es, ev}));
      if (es) check("lat3_sdata", c, 137'(d3_srd), 137'(d));
      if (ev) check("lat3_vdata", c, 137'(d3_vrd), 137'(d));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
